// File: rtl/prg_seed_gen.sv
// prg_seed_gen: 32-bit Galois LFSR seed source with a req/valid/ack handshake.
// Every delivered word has prg_seed[4:0] != prg_seed[9:5] so the downstream
// index picker never draws the same individual twice.
module prg_seed_gen #(
    parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468,
    parameter logic [31:0] POLY         = 32'h8020_0003,
    parameter int unsigned MAX_STEPS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    input  logic        req,
    input  logic        ack,
    output logic [31:0] prg_seed,
    output logic        valid,
    output logic        busy,
    output logic [15:0] draw_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Reject counter value on which the next reject is forced into an accept.
    localparam logic [3:0] REJ_LAST = 4'(MAX_STEPS - 1);

    state_e      state_q;
    logic [31:0] lfsr_q;
    logic [31:0] prg_q;
    logic        valid_q;
    logic        busy_q;
    logic [15:0] cnt_q;
    logic [3:0]  rej_q;

    logic [31:0] lfsr_d;
    logic [31:0] forced_d;
    logic        cand_ok;

    // One Galois step of the LFSR and the acceptance test on its index fields.
    // The forced word keeps the low field and flips bit 0 of it into the high
    // field, so the two fields always differ.
    always_comb begin
        lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
        cand_ok  = (lfsr_d[4:0] != lfsr_d[9:5]);
        forced_d = {lfsr_d[31:10], lfsr_d[4:0] ^ 5'd1, lfsr_d[4:0]};
    end

    // Control FSM with registered outputs; seed_load overrides every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_DEFAULT;
            prg_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            rej_q   <= '0;
        end else if (seed_load) begin
            // A zero seed would lock the LFSR at zero forever.
            lfsr_q  <= (seed_in == '0) ? SEED_DEFAULT : seed_in;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= STEP;
                        busy_q  <= 1'b1;
                        rej_q   <= '0;
                    end
                end
                STEP: begin
                    // The LFSR always advances by the unforced value.
                    lfsr_q <= lfsr_d;
                    if (cand_ok || (rej_q == REJ_LAST)) begin
                        prg_q   <= cand_ok ? lfsr_d : forced_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= cnt_q + 16'd1;
                        state_q <= HOLD;
                    end else begin
                        rej_q <= rej_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign prg_seed = prg_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign draw_cnt = cnt_q;

endmodule

// File: tb/tb_prg_seed_gen.sv
// Bench for prg_seed_gen: two instances (MAX_STEPS 8 and 1) share stimulus;
// each is checked against a draw-level reference model.
module tb_prg_seed_gen;

    localparam logic [31:0] DEF  = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = '0;
    logic        req = 1'b0;
    logic        ack = 1'b0;

    logic [31:0] prg8, prg1;
    logic        vld8, vld1, busy8, busy1;
    logic [15:0] cnt8, cnt1;

    prg_seed_gen #(.MAX_STEPS(8)) u_dut8 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .ack(ack), .prg_seed(prg8), .valid(vld8), .busy(busy8),
        .draw_cnt(cnt8)
    );

    prg_seed_gen #(.MAX_STEPS(1)) u_dut1 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .ack(ack), .prg_seed(prg1), .valid(vld1), .busy(busy1),
        .draw_cnt(cnt1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: LFSR, expected delivered word and draw count per instance
    logic [31:0] ml8, ml1, mp8, mp1;
    logic [15:0] mc8, mc1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] stp(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    // Whole draw in one go: advance until the fields differ or the budget runs out.
    task automatic mdraw(inout logic [31:0] l, input int maxs,
                         output logic [31:0] w, output int s);
        w = '0;
        s = 0;
        for (int i = 1; i <= maxs; i++) begin
            l = stp(l);
            s = i;
            if (l[4:0] != l[9:5]) begin
                w = l;
                break;
            end
            if (i == maxs) w = {l[31:10], l[4:0] ^ 5'd1, l[4:0]};
        end
    endtask

    task automatic model_reset();
        ml8 = DEF; ml1 = DEF; mp8 = '0; mp1 = '0; mc8 = '0; mc1 = '0;
    endtask

    task automatic load(input logic [31:0] v);
        seed_in = v; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        ml8 = (v == 0) ? DEF : v;
        ml1 = ml8;
        chk("load_vld", {31'd0, vld8}, 32'd0);
        chk("load_busy", {31'd0, busy8}, 32'd0);
        chk("load_prg", prg8, mp8);
        chk("load_cnt1", {16'd0, cnt1}, {16'd0, mc1});
    endtask

    task automatic draw();
        logic [31:0] w8, w1;
        int s8, s1, cyc, bc;
        mdraw(ml8, 8, w8, s8);
        mdraw(ml1, 1, w1, s1);
        req = 1'b1;
        tick();
        req = 1'b0;
        cyc = 0; bc = 0;
        while (!vld8 && cyc < 40) begin
            if (busy8) bc++;
            tick();
            cyc++;
        end
        mp8 = w8; mp1 = w1; mc8 = mc8 + 16'd1; mc1 = mc1 + 16'd1;
        chk("lat8", 32'(cyc), 32'(s8));
        chk("busycyc8", 32'(bc), 32'(s8));
        chk("busy_off8", {31'd0, busy8}, 32'd0);
        chk("seed8", prg8, mp8);
        chk("cnt8", {16'd0, cnt8}, {16'd0, mc8});
        chk("vld1", {31'd0, vld1}, 32'd1);
        chk("seed1", prg1, mp1);
        chk("cnt1", {16'd0, cnt1}, {16'd0, mc1});
    endtask

    task automatic release_ack(input logic with_req);
        ack = 1'b1; req = with_req;
        tick();
        ack = 1'b0; req = 1'b0;
        chk("ack_vld8", {31'd0, vld8}, 32'd0);
        chk("ack_vld1", {31'd0, vld1}, 32'd0);
        chk("ack_busy8", {31'd0, busy8}, 32'd0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'($urandom_range(0, 1));
            tick();
            req = 1'b0;
        end
        chk("hold_vld8", {31'd0, vld8}, 32'd1);
        chk("hold_prg8", prg8, mp8);
        chk("hold_prg1", prg1, mp1);
        chk("hold_cnt8", {16'd0, cnt8}, {16'd0, mc8});
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prg", prg8, 32'd0);
        chk("rst_vld", {31'd0, vld8}, 32'd0);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_cnt", {16'd0, cnt8}, 32'd0);
        rst = 1'b0;
        tick();

        // Seed 1: two back-to-back draws
        load(32'h1);
        draw();
        chk("d1_const", prg8, 32'h8020_0003);
        chk("d1_cnt", {16'd0, cnt8}, 32'd1);
        release_ack(1'b0);
        draw();
        chk("d2_const", prg8, 32'hC030_0002);
        chk("d2_cnt", {16'd0, cnt8}, 32'd2);
        release_ack(1'b0);

        // One reject, and forced accept on the MAX_STEPS=1 instance
        load(32'h42);
        draw();
        chk("rej_const8", prg8, 32'h8020_0013);
        chk("forced_const1", prg1, 32'h0000_0001);
        release_ack(1'b0);
        draw();
        chk("after_forced1", prg1, 32'h8020_0013);

        // Long hold with ignored req pulses, then seed_load in HOLD
        hold(10);
        load(32'h0);
        chk("prg_kept1", prg1, mp1);

        // Zero seed falls back to the default
        draw();
        chk("zero_const8", prg8, 32'h5670_9234);
        chk("zero_const1", prg1, 32'h5670_9234);
        release_ack(1'b0);

        // seed_load beats a simultaneous req; the req is not queued
        seed_in = 32'h1234_5678; seed_load = 1'b1; req = 1'b1;
        tick();
        seed_load = 1'b0; req = 1'b0;
        ml8 = 32'h1234_5678; ml1 = ml8;
        chk("ldreq_busy", {31'd0, busy8}, 32'd0);
        tick();
        chk("ldreq_drop", {31'd0, busy8}, 32'd0);

        // seed_load aborts a draw in STEP
        load(32'h42);
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("abort_busy_pre", {31'd0, busy8}, 32'd1);
        seed_in = 32'h0BAD_F00D; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        ml8 = 32'h0BAD_F00D; ml1 = ml8;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_vld1", {31'd0, vld1}, 32'd0);
        chk("abort_prg8", prg8, mp8);
        chk("abort_cnt1", {16'd0, cnt1}, {16'd0, mc1});
        draw();
        release_ack(1'b0);

        // Async reset in the middle of STEP
        load(32'h42);
        req = 1'b1;
        tick();
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", {31'd0, vld8}, 32'd0);
        chk("arst_busy", {31'd0, busy8}, 32'd0);
        chk("arst_prg", prg8, 32'd0);
        chk("arst_cnt", {16'd0, cnt8}, 32'd0);
        rst = 1'b0;
        model_reset();
        tick();
        draw();
        chk("arst_draw", prg8, 32'h5670_9234);
        release_ack(1'b0);

        // Randomized draws, seed loads and hold lengths
        for (int n = 0; n < 200; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) load(32'h0);
            else if (r < 3) load($urandom);
            else if (r == 3) load({22'd0, 10'($urandom)});
            draw();
            hold(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) load($urandom);
            else release_ack(1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
